// File: rtl/dma_priority_arbiter_if.sv
// Request/acknowledge bundle between the 8237A-style DMA arbiter and its
// surroundings (pins, register file, CPU hold logic, timing FSM).
//   slave  : arbiter side. It samples requests, controls and handshakes, and
//            drives hrq, svc_start, ch_sel, dack and the two status vectors.
//   master : environment side, with the directions reversed.
interface dma_priority_arbiter_if #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2
);
    logic [NUM_CH-1:0] dreq;
    logic              dreq_sense_low;
    logic              dack_sense_high;
    logic              rotating_pri;
    logic              ctrl_disable;
    logic              mask_wr;
    logic [NUM_CH-1:0] mask_data;
    logic              smask_wr;
    logic [2:0]        smask_data;
    logic              sreq_wr;
    logic [2:0]        sreq_data;
    logic [NUM_CH-1:0] autoinit;
    logic              hlda;
    logic              svc_done;
    logic              tc;
    logic              hrq;
    logic              svc_start;
    logic [CH_W-1:0]   ch_sel;
    logic [NUM_CH-1:0] dack;
    logic [NUM_CH-1:0] mask_status;
    logic [NUM_CH-1:0] req_status;

    modport slave (
        input  dreq, dreq_sense_low, dack_sense_high, rotating_pri, ctrl_disable,
               mask_wr, mask_data, smask_wr, smask_data, sreq_wr, sreq_data,
               autoinit, hlda, svc_done, tc,
        output hrq, svc_start, ch_sel, dack, mask_status, req_status
    );

    modport master (
        output dreq, dreq_sense_low, dack_sense_high, rotating_pri, ctrl_disable,
               mask_wr, mask_data, smask_wr, smask_data, sreq_wr, sreq_data,
               autoinit, hlda, svc_done, tc,
        input  hrq, svc_start, ch_sel, dack, mask_status, req_status
    );
endinterface

// File: rtl/dma_priority_arbiter.sv
// Request resolver and bus-hold sequencer for the 4-channel DMA core.
// Conditions DREQ (synchronise, polarity, software requests, masks), arbitrates
// with fixed or rotating priority, runs the HRQ/HLDA handshake and holds the
// winning channel on ch_sel/dack until the timing FSM reports svc_done.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : dma_priority_arbiter_if.slave (requests, controls, handshakes, status)
module dma_priority_arbiter #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    dma_priority_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        GRANT   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state;
    logic [NUM_CH-1:0] sync1;
    logic [NUM_CH-1:0] sync2;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] sreq;
    logic [NUM_CH-1:0] ack;
    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   ch_sel;
    logic              hrq;
    logic              svc_start;

    logic [NUM_CH-1:0] req_c;
    logic [NUM_CH-1:0] valid_c;
    logic [CH_W-1:0]   start_c;
    logic [CH_W-1:0]   win_c;
    logic [CH_W-1:0]   ptr_next_c;
    logic [NUM_CH-1:0] mask_nxt_c;
    logic [NUM_CH-1:0] sreq_nxt_c;

    // First requesting channel found when searching upward from s, wrapping.
    function automatic logic [CH_W-1:0] pick(input logic [NUM_CH-1:0] v,
                                             input logic [CH_W-1:0]   s);
        logic [CH_W-1:0] r;
        logic            found;
        int unsigned     idx;
        r     = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            idx = (32'(s) + i) % NUM_CH;
            if (!found && v[idx]) begin
                r     = CH_W'(idx);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // Conditioned requests and arbitration winner.
    always_comb begin
        req_c   = (sync2 ^ {NUM_CH{bus.dreq_sense_low}}) | sreq;
        valid_c = req_c & ~mask;
        start_c = bus.rotating_pri ? ptr : '0;
        win_c   = pick(valid_c, start_c);
        ptr_next_c = (32'(ch_sel) == NUM_CH - 1) ? '0 : ch_sel + CH_W'(1);
    end

    // Mask / software-request update; register writes land after the TC side
    // effects so that a same-edge write wins for the bits it touches.
    always_comb begin
        mask_nxt_c = mask;
        sreq_nxt_c = sreq;
        if (state == GRANT && bus.svc_done && bus.tc) begin
            sreq_nxt_c[ch_sel] = 1'b0;
            if (!bus.autoinit[ch_sel])
                mask_nxt_c[ch_sel] = 1'b1;
        end
        if (bus.mask_wr)
            mask_nxt_c = bus.mask_data;
        if (bus.smask_wr)
            mask_nxt_c[bus.smask_data[CH_W-1:0]] = bus.smask_data[2];
        if (bus.sreq_wr)
            sreq_nxt_c[bus.sreq_data[CH_W-1:0]] = bus.sreq_data[2];
    end

    // Synchroniser, register state and HRQ/HLDA sequencer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            sync1     <= '0;
            sync2     <= '0;
            mask      <= '1;
            sreq      <= '0;
            ack       <= '0;
            ptr       <= '0;
            ch_sel    <= '0;
            hrq       <= 1'b0;
            svc_start <= 1'b0;
        end else begin
            sync1     <= bus.dreq;
            sync2     <= sync1;
            mask      <= mask_nxt_c;
            sreq      <= sreq_nxt_c;
            svc_start <= 1'b0;
            case (state)
                IDLE: begin
                    // hlda guard keeps HRQ down until the CPU has let go.
                    if (|valid_c && !bus.ctrl_disable && !bus.hlda) begin
                        state <= REQ;
                        hrq   <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.hlda) begin
                        if (|valid_c) begin
                            state     <= GRANT;
                            ch_sel    <= win_c;
                            svc_start <= 1'b1;
                            ack       <= NUM_CH'(1) << win_c;
                        end else begin
                            // Request vanished before the bus arrived.
                            state <= RELEASE;
                            hrq   <= 1'b0;
                        end
                    end
                end
                GRANT: begin
                    if (bus.svc_done) begin
                        state <= RELEASE;
                        hrq   <= 1'b0;
                        ack   <= '0;
                        if (bus.rotating_pri)
                            ptr <= ptr_next_c;
                    end
                end
                RELEASE: begin
                    if (!bus.hlda)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.hrq         = hrq;
    assign bus.svc_start   = svc_start;
    assign bus.ch_sel      = ch_sel;
    assign bus.dack        = bus.dack_sense_high ? ack : ~ack;
    assign bus.mask_status = mask;
    assign bus.req_status  = req_c;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Bench for dma_priority_arbiter: expected grant channels are queued when the
// request pattern is applied and popped when the DUT pulses svc_start.
module tb_dma_priority_arbiter;

    logic clk;
    logic reset_n;

    dma_priority_arbiter_if #(.NUM_CH(4), .CH_W(2)) bus ();

    dma_priority_arbiter #(.NUM_CH(4), .CH_W(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [1:0] exp_q[$];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic init_inputs();
        bus.dreq            = '0;
        bus.dreq_sense_low  = 1'b0;
        bus.dack_sense_high = 1'b0;
        bus.rotating_pri    = 1'b0;
        bus.ctrl_disable    = 1'b0;
        bus.mask_wr         = 1'b0;
        bus.mask_data       = '0;
        bus.smask_wr        = 1'b0;
        bus.smask_data      = '0;
        bus.sreq_wr         = 1'b0;
        bus.sreq_data       = '0;
        bus.autoinit        = '0;
        bus.hlda            = 1'b0;
        bus.svc_done        = 1'b0;
        bus.tc              = 1'b0;
    endtask

    // Drives one full bus-hold cycle; returns what the DUT did on the grant.
    task automatic serve(input logic tc_v, input logic [3:0] dreq_after,
                         output logic started, output logic [1:0] ch,
                         output logic [3:0] dk);
        int w;
        started = 1'b0;
        ch      = '0;
        dk      = '0;
        w       = 0;
        while (bus.hrq !== 1'b1 && w < 12) begin
            step(1);
            w++;
        end
        if (bus.hrq !== 1'b1) return;
        bus.hlda = 1'b1;
        bus.dreq = dreq_after;
        step(1);
        started = bus.svc_start;
        ch      = bus.ch_sel;
        dk      = bus.dack;
        step(1);
        bus.svc_done = 1'b1;
        bus.tc       = tc_v;
        step(1);
        bus.svc_done = 1'b0;
        bus.tc       = 1'b0;
        bus.hlda     = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        init_inputs();
        step(2);
        checks++;
        if (bus.hrq !== 1'b0 || bus.svc_start !== 1'b0 || bus.ch_sel !== 2'd0) begin
            errors++;
            $display("FAIL reset_ctl: hrq=%b svc_start=%b ch_sel=%0d, want 0 0 0",
                     bus.hrq, bus.svc_start, bus.ch_sel);
        end
        checks++;
        if (bus.mask_status !== 4'hF || bus.dack !== 4'hF) begin
            errors++;
            $display("FAIL reset_vec: mask=%b dack=%b, want 1111 1111",
                     bus.mask_status, bus.dack);
        end
        reset_n = 1'b1;
        step(1);
    endtask

    task automatic test_basic_grant();
        bus.mask_wr   = 1'b1;
        bus.mask_data = 4'b0000;
        step(1);
        bus.mask_wr = 1'b0;
        bus.dreq    = 4'b0100;
        step(2);
        checks++;
        if (bus.hrq !== 1'b0) begin
            errors++;
            $display("FAIL hrq_early: hrq=%b after 2 edges, want 0", bus.hrq);
        end
        step(1);
        checks++;
        if (bus.hrq !== 1'b1) begin
            errors++;
            $display("FAIL hrq_latency: hrq=%b after 3 edges, want 1", bus.hrq);
        end
        exp_q.push_back(2'd2);
        bus.hlda = 1'b1;
        step(1);
        checks++;
        if (bus.svc_start !== 1'b1 || bus.ch_sel !== exp_q.pop_front() || bus.dack !== 4'b1011) begin
            errors++;
            $display("FAIL basic_grant: start=%b ch=%0d dack=%b, want 1 2 1011",
                     bus.svc_start, bus.ch_sel, bus.dack);
        end
        bus.dreq = 4'b0000;
        step(1);
        checks++;
        if (bus.svc_start !== 1'b0 || bus.dack !== 4'b1011) begin
            errors++;
            $display("FAIL grant_hold: start=%b dack=%b, want 0 1011", bus.svc_start, bus.dack);
        end
        bus.svc_done = 1'b1;
        step(1);
        bus.svc_done = 1'b0;
        checks++;
        if (bus.hrq !== 1'b0 || bus.dack !== 4'hF) begin
            errors++;
            $display("FAIL release: hrq=%b dack=%b, want 0 1111", bus.hrq, bus.dack);
        end
        bus.hlda = 1'b0;
        step(2);
    endtask

    task automatic test_fixed_priority();
        logic st;
        logic [1:0] ch, e;
        logic [3:0] dk;
        bus.rotating_pri = 1'b0;
        bus.dreq = 4'b1010;
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back(2'd1);
            serve(1'b0, (i == 1) ? 4'b0000 : 4'b1010, st, ch, dk);
            e = exp_q.pop_front();
            checks++;
            if (st !== 1'b1 || ch !== e) begin
                errors++;
                $display("FAIL fixed_grant%0d: start=%b ch=%0d, want 1 %0d", i, st, ch, e);
            end
        end
    endtask

    task automatic test_rotating();
        logic st;
        logic [1:0] ch, e;
        logic [3:0] dk;
        bus.rotating_pri = 1'b1;
        bus.dreq = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(2'(i % 4));
            serve(1'b0, (i == 4) ? 4'b0000 : 4'b1111, st, ch, dk);
            e = exp_q.pop_front();
            checks++;
            if (st !== 1'b1 || ch !== e) begin
                errors++;
                $display("FAIL rot_grant%0d: start=%b ch=%0d, want 1 %0d", i, st, ch, e);
            end
        end
        bus.rotating_pri = 1'b0;
    endtask

    task automatic test_tc_automask();
        logic st;
        logic [1:0] ch, e;
        logic [3:0] dk;
        bus.autoinit = 4'b0000;
        bus.dreq = 4'b1000;
        exp_q.push_back(2'd3);
        serve(1'b1, 4'b1000, st, ch, dk);
        e = exp_q.pop_front();
        checks++;
        if (st !== 1'b1 || ch !== e || dk !== 4'b0111) begin
            errors++;
            $display("FAIL tc_grant: start=%b ch=%0d dack=%b, want 1 %0d 0111", st, ch, dk, e);
        end
        checks++;
        if (bus.mask_status !== 4'b1000) begin
            errors++;
            $display("FAIL tc_mask: mask=%b, want 1000", bus.mask_status);
        end
        step(6);
        checks++;
        if (bus.hrq !== 1'b0 || bus.req_status !== 4'b1000) begin
            errors++;
            $display("FAIL masked_ignored: hrq=%b req=%b, want 0 1000", bus.hrq, bus.req_status);
        end
        bus.smask_wr   = 1'b1;
        bus.smask_data = 3'b011;
        bus.autoinit   = 4'b1000;
        step(1);
        bus.smask_wr = 1'b0;
        exp_q.push_back(2'd3);
        serve(1'b1, 4'b0000, st, ch, dk);
        e = exp_q.pop_front();
        checks++;
        if (st !== 1'b1 || ch !== e || bus.mask_status !== 4'b0000) begin
            errors++;
            $display("FAIL autoinit: start=%b ch=%0d mask=%b, want 1 %0d 0000",
                     st, ch, bus.mask_status, e);
        end
        bus.autoinit = 4'b0000;
    endtask

    task automatic test_soft_request();
        logic st;
        logic [1:0] ch, e;
        logic [3:0] dk;
        bus.autoinit  = 4'b0010;
        bus.sreq_wr   = 1'b1;
        bus.sreq_data = 3'b101;
        step(1);
        bus.sreq_wr = 1'b0;
        checks++;
        if (bus.hrq !== 1'b0 || bus.req_status !== 4'b0010) begin
            errors++;
            $display("FAIL sreq_set: hrq=%b req=%b, want 0 0010", bus.hrq, bus.req_status);
        end
        step(1);
        checks++;
        if (bus.hrq !== 1'b1) begin
            errors++;
            $display("FAIL sreq_latency: hrq=%b, want 1", bus.hrq);
        end
        exp_q.push_back(2'd1);
        serve(1'b1, 4'b0000, st, ch, dk);
        e = exp_q.pop_front();
        checks++;
        if (st !== 1'b1 || ch !== e || bus.req_status !== 4'b0000) begin
            errors++;
            $display("FAIL sreq_tc_clear: start=%b ch=%0d req=%b, want 1 %0d 0000",
                     st, ch, bus.req_status, e);
        end
        bus.autoinit = 4'b0000;
    endtask

    task automatic test_dreq_drop();
        logic st;
        logic [1:0] ch, e;
        logic [3:0] dk;
        int w;
        bus.dreq = 4'b0001;
        w = 0;
        while (bus.hrq !== 1'b1 && w < 8) begin
            step(1);
            w++;
        end
        bus.dreq = 4'b0000;
        step(3);
        checks++;
        if (bus.hrq !== 1'b1) begin
            errors++;
            $display("FAIL drop_hrq_held: hrq=%b, want 1", bus.hrq);
        end
        bus.hlda = 1'b1;
        step(1);
        checks++;
        if (bus.svc_start !== 1'b0 || bus.hrq !== 1'b0 || bus.dack !== 4'hF) begin
            errors++;
            $display("FAIL drop_no_grant: start=%b hrq=%b dack=%b, want 0 0 1111",
                     bus.svc_start, bus.hrq, bus.dack);
        end
        bus.dreq = 4'b0001;
        step(4);
        checks++;
        if (bus.hrq !== 1'b0) begin
            errors++;
            $display("FAIL hrq_while_hlda: hrq=%b, want 0", bus.hrq);
        end
        bus.hlda = 1'b0;
        exp_q.push_back(2'd0);
        serve(1'b0, 4'b0000, st, ch, dk);
        e = exp_q.pop_front();
        checks++;
        if (st !== 1'b1 || ch !== e) begin
            errors++;
            $display("FAIL drop_recover: start=%b ch=%0d, want 1 %0d", st, ch, e);
        end
    endtask

    task automatic test_ctrl_disable();
        logic st;
        logic [1:0] ch, e;
        logic [3:0] dk;
        bus.ctrl_disable = 1'b1;
        bus.dreq = 4'b0100;
        step(6);
        checks++;
        if (bus.hrq !== 1'b0) begin
            errors++;
            $display("FAIL ctrl_disable: hrq=%b, want 0", bus.hrq);
        end
        bus.ctrl_disable = 1'b0;
        exp_q.push_back(2'd2);
        serve(1'b0, 4'b0000, st, ch, dk);
        e = exp_q.pop_front();
        checks++;
        if (st !== 1'b1 || ch !== e) begin
            errors++;
            $display("FAIL ctrl_enable: start=%b ch=%0d, want 1 %0d", st, ch, e);
        end
    endtask

    task automatic test_reset_mid_service();
        int w;
        bus.dreq = 4'b0100;
        w = 0;
        while (bus.hrq !== 1'b1 && w < 8) begin
            step(1);
            w++;
        end
        bus.hlda = 1'b1;
        step(1);
        checks++;
        if (bus.dack !== 4'b1011) begin
            errors++;
            $display("FAIL pre_reset_dack: dack=%b, want 1011", bus.dack);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus.dack !== 4'hF || bus.hrq !== 1'b0 || bus.mask_status !== 4'hF ||
            bus.svc_start !== 1'b0 || bus.ch_sel !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: dack=%b hrq=%b mask=%b start=%b ch=%0d, want 1111 0 1111 0 0",
                     bus.dack, bus.hrq, bus.mask_status, bus.svc_start, bus.ch_sel);
        end
        bus.dreq = 4'b0000;
        bus.hlda = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(1);
    endtask

    initial begin
        test_reset();
        test_basic_grant();
        test_fixed_priority();
        test_rotating();
        test_tc_automask();
        test_soft_request();
        test_dreq_drop();
        test_ctrl_disable();
        test_reset_mid_service();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
